microprocessor_core: RTL and testbench

//  4-bit accumulator-style microprocessor: program sequencer, 256x8 program ROM, instruction decoder,

---
 rtl/microprocessor_core.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_microprocessor_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/microprocessor_core.sv
// -----------------------------------------------------------------------------
// microprocessor_core
//
// 4-bit accumulator-style processor: program sequencer, 256x8 program ROM,
// instruction decoder and computational unit (x0, x1, y0, y1, r, m, i, o_reg,
// 16x4 data memory, zero flag). All architectural state is exported as debug
// ports so a lab bench can signature-check every cycle.
//
// Parameters
//   PM_INIT_FILE  name of the program ROM image; the ROM array is filled by
//                 the surrounding environment
//
// Ports
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous, active-low reset (0 = reset)
//   i_pins      in   4  external input port
//   o_reg       out  4  output register
//   pm_address  out  8  next PC / ROM address (combinational)
//   pm_data     out  8  ROM output, equals rom[pc]
//   pc          out  8  program counter
//   ir          out  8  instruction executing this cycle
//   x0,x1,y0,y1 out  4  ALU operand registers
//   r           out  4  ALU result register
//   m           out  4  index increment register
//   i           out  4  data-memory index register
//   zero_flag   out  1  last ALU result was zero
//   from_PS/ID/CU out 8 reserved debug buses, tied to zero
//
// Instruction set (ir)
//   0ddd_nnnn  load immediate     dst <= nnnn
//   10dd_dsss  move               dst <= src (dst == src: dst <= i_pins)
//   110x_yfff  ALU                r <= f(X,Y), zero_flag <= (result == 0)
//   1110_aaaa  jump               pc <= {pc[7:4], aaaa}
//   1111_aaaa  jump if not zero   taken only when zero_flag == 0
//   Every jump has one delay slot: the next sequential instruction executes.
// -----------------------------------------------------------------------------
module microprocessor_core #(
  parameter string PM_INIT_FILE = "program_memory.hex"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_pins,
  output logic [3:0] o_reg,
  output logic [7:0] pm_address,
  output logic [7:0] pm_data,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic [3:0] x0,
  output logic [3:0] x1,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] r,
  output logic [3:0] m,
  output logic [3:0] i,
  output logic       zero_flag,
  output logic [7:0] from_PS,
  output logic [7:0] from_ID,
  output logic [7:0] from_CU
);

  // Register operand codes shared by load/move destinations and move sources.
  // Code 4 is o_reg as a destination but r as a source.
  typedef enum logic [2:0] {
    REG_X0    = 3'd0,
    REG_X1    = 3'd1,
    REG_Y0    = 3'd2,
    REG_Y1    = 3'd3,
    REG_OUT_R = 3'd4,
    REG_M     = 3'd5,
    REG_I     = 3'd6,
    REG_DM    = 3'd7
  } reg_code_e;

  typedef enum logic [2:0] {
    ALU_NEG   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_ADD   = 3'd2,
    ALU_MULHI = 3'd3,
    ALU_MULLO = 3'd4,
    ALU_XOR   = 3'd5,
    ALU_AND   = 3'd6,
    ALU_NOT   = 3'd7
  } alu_op_e;

  // ---------------------------------------------------------------------------
  // Program ROM
  // ---------------------------------------------------------------------------
  logic [7:0] rom [256];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q;
  logic [7:0] pm_data_q;
  logic [3:0] x0_q, x0_d;
  logic [3:0] x1_q, x1_d;
  logic [3:0] y0_q, y0_d;
  logic [3:0] y1_q, y1_d;
  logic [3:0] r_q, r_d;
  logic [3:0] m_q, m_d;
  logic [3:0] i_q, i_d;
  logic [3:0] o_q, o_d;
  logic       zf_q, zf_d;
  logic [3:0] dm_q [16];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic      is_load, is_move, is_alu, is_jump, jump_taken;
  reg_code_e dst, src;

  always_comb begin
    is_load    = ~ir_q[7];
    is_move    = (ir_q[7:6] == 2'b10);
    is_alu     = (ir_q[7:5] == 3'b110);
    is_jump    = (ir_q[7:5] == 3'b111);
    // ir[4] distinguishes jnz from the unconditional jump.
    jump_taken = is_jump && (~ir_q[4] || ~zf_q);
    dst        = reg_code_e'(is_load ? ir_q[6:4] : ir_q[5:3]);
    src        = reg_code_e'(ir_q[2:0]);
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next address drives both the PC and the registered ROM read,
  // so pm_data always shows rom[pc].
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!reset)          pc_d = 8'h00;
    else if (jump_taken) pc_d = {pc_q[7:4], ir_q[3:0]};
    else                 pc_d = pc_q + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Move source selection
  // ---------------------------------------------------------------------------
  logic [3:0] src_val;

  always_comb begin
    src_val = 4'd0;
    case (src)
      REG_X0:    src_val = x0_q;
      REG_X1:    src_val = x1_q;
      REG_Y0:    src_val = y0_q;
      REG_Y1:    src_val = y1_q;
      REG_OUT_R: src_val = r_q;
      REG_M:     src_val = m_q;
      REG_I:     src_val = i_q;
      REG_DM:    src_val = dm_q[i_q];
      default:   src_val = 4'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [3:0] alu_x, alu_y, alu_res;
  logic [7:0] product;

  always_comb begin
    alu_x   = ir_q[4] ? x1_q : x0_q;
    alu_y   = ir_q[3] ? y1_q : y0_q;
    product = {4'd0, alu_x} * {4'd0, alu_y};
    alu_res = 4'd0;
    case (alu_op_e'(ir_q[2:0]))
      ALU_NEG:   alu_res = 4'd0 - alu_x;
      ALU_SUB:   alu_res = alu_x - alu_y;
      ALU_ADD:   alu_res = alu_x + alu_y;
      ALU_MULHI: alu_res = product[7:4];
      ALU_MULLO: alu_res = product[3:0];
      ALU_XOR:   alu_res = alu_x ^ alu_y;
      ALU_AND:   alu_res = alu_x & alu_y;
      ALU_NOT:   alu_res = ~alu_x;
      default:   alu_res = 4'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  logic [3:0] wr_val;
  logic       dm_access;
  logic       dm_we;
  logic [3:0] dm_wdata;

  // NOTE: every signal assigned here gets a default at the top, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    r_d       = r_q;
    m_d       = m_q;
    i_d       = i_q;
    o_d       = o_q;
    zf_d      = zf_q;
    wr_val    = 4'd0;
    dm_access = 1'b0;
    dm_we     = 1'b0;
    dm_wdata  = 4'd0;

    if (is_load || is_move) begin
      if (is_load)         wr_val = ir_q[3:0];
      else if (dst == src) wr_val = i_pins;
      else                 wr_val = src_val;

      // Any dm[i] access post-increments i; an explicit write to i below
      // overrides the increment.
      dm_access = (dst == REG_DM) || (is_move && (src == REG_DM));
      if (dm_access) i_d = i_q + m_q;

      case (dst)
        REG_X0:    x0_d = wr_val;
        REG_X1:    x1_d = wr_val;
        REG_Y0:    y0_d = wr_val;
        REG_Y1:    y1_d = wr_val;
        REG_OUT_R: o_d  = wr_val;
        REG_M:     m_d  = wr_val;
        REG_I:     i_d  = wr_val;
        REG_DM: begin
          dm_we    = 1'b1;
          dm_wdata = wr_val;
        end
        default: ;
      endcase
    end

    if (is_alu) begin
      r_d  = alu_res;
      zf_d = (alu_res == 4'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples the values from
  // before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= 8'h00;
      ir_q <= 8'h00;
      x0_q <= 4'd0;
      x1_q <= 4'd0;
      y0_q <= 4'd0;
      y1_q <= 4'd0;
      r_q  <= 4'd0;
      m_q  <= 4'd0;
      i_q  <= 4'd0;
      o_q  <= 4'd0;
      zf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ir_q <= pm_data_q;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y0_q <= y0_d;
      y1_q <= y1_d;
      r_q  <= r_d;
      m_q  <= m_d;
      i_q  <= i_d;
      o_q  <= o_d;
      zf_q <= zf_d;
    end
  end

  // NOTE: the ROM output register and the data memory carry no reset; they
  // map onto plain RAM/ROM blocks and dm keeps its contents across reset.
  always_ff @(posedge clk) begin
    pm_data_q <= rom[pc_d];
  end

  always_ff @(posedge clk) begin
    if (reset && dm_we) dm_q[i_q] <= dm_wdata;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pm_address = pc_d;
  assign pm_data    = pm_data_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign x0         = x0_q;
  assign x1         = x1_q;
  assign y0         = y0_q;
  assign y1         = y1_q;
  assign r          = r_q;
  assign m          = m_q;
  assign i          = i_q;
  assign o_reg      = o_q;
  assign zero_flag  = zf_q;
  assign from_PS    = 8'h00;
  assign from_ID    = 8'h00;
  assign from_CU    = 8'h00;

endmodule

// File: tb/tb_microprocessor_core.sv
// -----------------------------------------------------------------------------
// tb_microprocessor_core
//
// Instruction-level reference model of the processor, stepped on every rising
// edge, compared against every DUT output on every falling edge. Directed
// programs exercise ALU ops, moves/loads, data-memory indexing, jumps with
// delay slot, jnz fall-through, PC wrap and mid-program reset, with literal
// expectations at key points.
// -----------------------------------------------------------------------------
module tb_microprocessor_core;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic [3:0] i_pins = 4'h9;

  logic [3:0] o_reg, x0, x1, y0, y1, r, m, i;
  logic [7:0] pm_address, pm_data, pc, ir, from_PS, from_ID, from_CU;
  logic       zero_flag;

  always #5 clk = ~clk;

  microprocessor_core #(.PM_INIT_FILE("")) dut (
    .clk        (clk),
    .reset      (reset),
    .i_pins     (i_pins),
    .o_reg      (o_reg),
    .pm_address (pm_address),
    .pm_data    (pm_data),
    .pc         (pc),
    .ir         (ir),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .r          (r),
    .m          (m),
    .i          (i),
    .zero_flag  (zero_flag),
    .from_PS    (from_PS),
    .from_ID    (from_ID),
    .from_CU    (from_CU)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Programs (first 16 bytes; the rest of the ROM is 00)
  // ---------------------------------------------------------------------------
  logic [7:0] prog_a [16] = '{8'h01, 8'h22, 8'hC2, 8'h02, 8'hC1, 8'hF9, 8'h0F, 8'h2F,
                              8'hC3, 8'h8C, 8'hED, 8'hC4, 8'h3A, 8'hA4, 8'hEE, 8'h37};
  logic [7:0] prog_b [16] = '{8'h6F, 8'h51, 8'h7A, 8'h73, 8'h6F, 8'h8F, 8'h97, 8'hBF,
                              8'h61, 8'hA7, 8'h6F, 8'hB7, 8'hEC, 8'h00, 8'h00, 8'h00};
  logic [7:0] prog_c [16] = '{8'h03, 8'h21, 8'hC1, 8'h84, 8'hF2, 8'h55, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] prog [256];
  logic [3:0] gpr [4];          // x0, x1, y0, y1
  logic [3:0] m_r, m_o, m_m, m_i;
  logic [3:0] m_dm [16];
  logic       m_zf;
  logic [7:0] m_pc, m_ir, m_pmd;
  bit         model_valid = 0;

  task automatic load_prog(input int which);
    logic [7:0] v;
    for (int k = 0; k < 256; k++) begin
      v = 8'h00;
      if (k < 16) begin
        case (which)
          0:       v = prog_a[k];
          1:       v = prog_b[k];
          default: v = prog_c[k];
        endcase
      end
      prog[k]     = v;
      dut.rom[k]  = v;
    end
  endtask

  function automatic logic [7:0] exp_next_addr(input logic rst);
    if (!rst) return 8'h00;
    if (m_ir[7:5] == 3'b111 && (m_ir[4] == 1'b0 || !m_zf))
      return {m_pc[7:4], m_ir[3:0]};
    return m_pc + 8'd1;
  endfunction

  function automatic logic [3:0] read_reg(input int code);
    case (code)
      0, 1, 2, 3: return gpr[code];
      4:          return m_r;
      5:          return m_m;
      6:          return m_i;
      default:    return m_dm[m_i];
    endcase
  endfunction

  task automatic write_reg(input int code, input logic [3:0] v, input bit access);
    logic [3:0] old_i;
    old_i = m_i;
    if (access) m_i = m_i + m_m;
    case (code)
      0, 1, 2, 3: gpr[code] = v;
      4:          m_o = v;
      5:          m_m = v;
      6:          m_i = v;
      default:    m_dm[old_i] = v;
    endcase
  endtask

  task automatic model_step(input logic rst, input logic [3:0] pins);
    logic [7:0] nxt;
    int         dst, src, x, y, res;
    nxt = exp_next_addr(rst);
    if (!rst) begin
      for (int k = 0; k < 4; k++) gpr[k] = 4'd0;
      m_r = 0; m_o = 0; m_m = 0; m_i = 0; m_zf = 0;
      m_pc = 8'h00; m_ir = 8'h00; m_pmd = prog[0];
      return;
    end
    if (m_ir[7] == 1'b0) begin
      dst = int'(m_ir[6:4]);
      write_reg(dst, m_ir[3:0], dst == 7);
    end else if (m_ir[7:6] == 2'b10) begin
      dst = int'(m_ir[5:3]);
      src = int'(m_ir[2:0]);
      write_reg(dst, (dst == src) ? pins : read_reg(src), dst == 7 || src == 7);
    end else if (m_ir[7:5] == 3'b110) begin
      x = int'(m_ir[4] ? gpr[1] : gpr[0]);
      y = int'(m_ir[3] ? gpr[3] : gpr[2]);
      case (int'(m_ir[2:0]))
        0:       res = (16 - x) % 16;
        1:       res = (x - y + 16) % 16;
        2:       res = (x + y) % 16;
        3:       res = (x * y) / 16;
        4:       res = (x * y) % 16;
        5:       res = x ^ y;
        6:       res = x & y;
        default: res = 15 - x;
      endcase
      m_r  = 4'(res);
      m_zf = (res == 0);
    end
    m_ir  = m_pmd;
    m_pmd = prog[nxt];
    m_pc  = nxt;
  endtask

  always @(posedge clk) begin
    model_step(reset, i_pins);
    if (!reset) model_valid = 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("pc",         {24'd0, pc},         {24'd0, m_pc});
      check("ir",         {24'd0, ir},         {24'd0, m_ir});
      check("pm_data",    {24'd0, pm_data},    {24'd0, m_pmd});
      check("pm_address", {24'd0, pm_address}, {24'd0, exp_next_addr(reset)});
      check("x0",         {28'd0, x0},         {28'd0, gpr[0]});
      check("x1",         {28'd0, x1},         {28'd0, gpr[1]});
      check("y0",         {28'd0, y0},         {28'd0, gpr[2]});
      check("y1",         {28'd0, y1},         {28'd0, gpr[3]});
      check("r",          {28'd0, r},          {28'd0, m_r});
      check("m",          {28'd0, m},          {28'd0, m_m});
      check("i",          {28'd0, i},          {28'd0, m_i});
      check("o_reg",      {28'd0, o_reg},      {28'd0, m_o});
      check("zero_flag",  {31'd0, zero_flag},  {31'd0, m_zf});
      check("debug_bus",  {8'd0, from_PS, from_ID, from_CU}, 32'd0);
    end
  end

  // Advance n rising edges; returns 1 time unit after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit found;

    // Reset state and sequencing from 00.
    load_prog(0);
    edges(2);
    check("rst_pc",   {24'd0, pc}, 32'h00);
    check("rst_ir",   {24'd0, ir}, 32'h00);
    check("rst_regs", {x0, x1, y0, y1, r, m, i, o_reg}, 32'h0);
    check("rst_zf",   {31'd0, zero_flag}, 32'd0);
    reset = 1'b1;
    edges(1);
    check("seq_pc1", {24'd0, pc}, 32'h01);
    edges(1);
    check("seq_pc2", {24'd0, pc}, 32'h02);
    edges(2);
    check("add_r",  {28'd0, r}, 32'h3);
    check("add_zf", {31'd0, zero_flag}, 32'd0);
    edges(2);
    check("sub_r",  {28'd0, r}, 32'h0);
    check("sub_zf", {31'd0, zero_flag}, 32'd1);
    edges(1);
    check("jnz_fall_pc", {24'd0, pc}, 32'h07);
    edges(3);
    check("mulhi_r", {28'd0, r}, 32'hE);
    edges(30);
    check("a_x1_hi",    {28'd0, x1},    32'hE);
    check("a_mullo_r",  {28'd0, r},     32'h1);
    check("a_pins_out", {28'd0, o_reg}, 32'h9);
    check("a_slot_y1",  {28'd0, y1},    32'h7);
    check("a_y0",       {28'd0, y0},    32'hF);

    // Data memory indexing program.
    reset = 1'b0;
    edges(1);
    load_prog(1);
    edges(2);
    reset  = 1'b1;
    i_pins = 4'h6;
    edges(4);
    check("b_i_wrap", {28'd0, i}, 32'h0);
    edges(26);
    check("b_x1_dmF",  {28'd0, x1},    32'hA);
    check("b_y0_dm0",  {28'd0, y0},    32'h3);
    check("b_o_dm1",   {28'd0, o_reg}, 32'h6);
    check("b_i_moved", {28'd0, i},     32'hA);
    check("b_m",       {28'd0, m},     32'h1);

    // Countdown loop, PC wrap, mid-loop reset.
    reset = 1'b0;
    edges(1);
    load_prog(2);
    edges(2);
    reset  = 1'b1;
    i_pins = 4'h5;
    found  = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (pc == 8'hFF) found = 1;
      else edges(1);
    end
    check("c_reach_ff", {31'd0, found}, 32'd1);
    edges(1);
    check("c_wrap_pc", {24'd0, pc}, 32'h00);
    edges(5);
    reset = 1'b0;
    edges(1);
    check("c_rst_pc", {24'd0, pc}, 32'h00);
    check("c_rst_ir", {24'd0, ir}, 32'h00);
    check("c_rst_x0", {28'd0, x0}, 32'h0);
    reset = 1'b1;
    edges(1);
    check("c_restart_pc", {24'd0, pc}, 32'h01);
    edges(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
